// File: rtl/event_stream_buffer_if.sv
// Stream handshake bundle for the event buffer output.
// Latency: n/a (signal bundle only). Backpressure: consumer holds m_ready low to stall beats.
// Signals: m_data/m_valid/m_last driven by the buffer (master); m_ready driven by the consumer (slave).
interface event_stream_buffer_if;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;

  modport master (output m_data, output m_valid, output m_last, input m_ready);
  modport slave  (input m_data, input m_valid, input m_last, output m_ready);
endinterface

// File: rtl/event_stream_buffer.sv
// Event buffer: queues classified events in a DEPTH-entry FIFO and streams them out as records.
// Latency: an event written into an empty FIFO is first presented the next cycle (no bypass).
// Backpressure: beats hold while m_ready=0; writes arriving while full are dropped and counted.
//
// Ports: clk/rst (sync, active-high); event_in/event_valid (event source); spike_in (raw
// spike flag); stream (master modport: m_data/m_valid/m_last out, m_ready in);
// fill_level, drop_count, overflow, spike_count (status).
// Build option EVENT_TIMESTAMP_EN: adds a free-running 32-bit timestamp stored with each
// event, and each record becomes two beats (timestamp head, event-word tail). Without it,
// each record is a single beat carrying the event word with m_last=1.
module event_stream_buffer #(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            event_in,
  input  logic                   event_valid,
  input  logic                   spike_in,
  event_stream_buffer_if.master  stream,
  output logic [$clog2(DEPTH):0] fill_level,
  output logic [15:0]            drop_count,
  output logic                   overflow,
  output logic [15:0]            spike_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

`ifdef EVENT_TIMESTAMP_EN
  localparam int EW = 64;
`else
  localparam int EW = 32;
`endif

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [EW-1:0] wr_entry;
  logic [EW-1:0] rd_entry;
  logic          full;
  logic          valid;
  logic          wr_acc;
  logic          pop;
  logic [31:0]   beat_data;
  logic          beat_last;

  // Full is judged on the registered level, so a pop in the same cycle cannot make room.
  assign full     = (fill_level == FULL_LEVEL);
  assign valid    = (fill_level != '0);
  assign wr_acc   = event_valid && !full;
  assign rd_entry = mem[rd_ptr];

`ifdef EVENT_TIMESTAMP_EN
  typedef enum logic {BEAT_HEAD, BEAT_TAIL} beat_state_t;

  logic [31:0] timestamp;
  beat_state_t state;
  beat_state_t state_nxt;

  always_ff @(posedge clk) begin
    if (rst) timestamp <= '0;
    else     timestamp <= timestamp + 32'd1;
  end

  assign wr_entry = {timestamp, event_in};

  always_ff @(posedge clk) begin
    if (rst) state <= BEAT_HEAD;
    else     state <= state_nxt;
  end

  // Head beat carries the timestamp; the entry is popped only once its tail beat transfers.
  always_comb begin
    state_nxt = state;
    beat_data = '0;
    beat_last = 1'b0;
    pop       = 1'b0;
    case (state)
      BEAT_HEAD: begin
        if (valid) begin
          beat_data = rd_entry[63:32];
          if (stream.m_ready) state_nxt = BEAT_TAIL;
        end
      end
      BEAT_TAIL: begin
        // The entry being sent is still stored, so valid is high throughout the tail.
        beat_data = rd_entry[31:0];
        beat_last = 1'b1;
        if (stream.m_ready) begin
          pop       = 1'b1;
          state_nxt = BEAT_HEAD;
        end
      end
      default: state_nxt = BEAT_HEAD;
    endcase
  end
`else
  assign wr_entry = event_in;

  always_comb begin
    beat_data = valid ? rd_entry : '0;
    beat_last = valid;
    pop       = valid && stream.m_ready;
  end
`endif

  assign stream.m_valid = valid;
  assign stream.m_data  = beat_data;
  assign stream.m_last  = beat_last;

  // Storage needs no reset: the pointers and level alone decide what is visible.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) mem[wr_ptr] <= wr_entry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fill_level  <= '0;
      drop_count  <= '0;
      overflow    <= 1'b0;
      spike_count <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (pop)    rd_ptr <= rd_ptr + AW'(1);

      case ({wr_acc, pop})
        2'b10:   fill_level <= fill_level + (AW+1)'(1);
        2'b01:   fill_level <= fill_level - (AW+1)'(1);
        default: fill_level <= fill_level;
      endcase

      if (event_valid && full) begin
        overflow <= 1'b1;
        if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      end

      if (spike_in && (spike_count != 16'hFFFF)) spike_count <= spike_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_event_stream_buffer.sv
// Self-checking bench for event_stream_buffer: directed vector table, hand-written
// corner sequences (overflow, mid-record reset, spike saturation) and random traffic
// compared each cycle against a beat-queue reference model.
module tb_event_stream_buffer;
  localparam int DEPTH = 16;
`ifdef EVENT_TIMESTAMP_EN
  localparam int BPR = 2;
`else
  localparam int BPR = 1;
`endif

  logic                   clk = 1'b0;
  logic                   rst;
  logic [31:0]            event_in;
  logic                   event_valid;
  logic                   spike_in;
  logic [$clog2(DEPTH):0] fill_level;
  logic [15:0]            drop_count;
  logic                   overflow;
  logic [15:0]            spike_count;

  event_stream_buffer_if sif ();

  event_stream_buffer #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .event_in    (event_in),
    .event_valid (event_valid),
    .spike_in    (spike_in),
    .stream      (sif),
    .fill_level  (fill_level),
    .drop_count  (drop_count),
    .overflow    (overflow),
    .spike_count (spike_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the expected output as a queue of beats still to be sent.
  typedef struct {
    logic [31:0] d;
    logic        l;
  } beat_t;

  beat_t       mq[$];
  logic [31:0] m_ts;
  int          m_drop;
  int          m_spk;
  bit          m_ovf;
  bit          do_chk;

  function automatic int model_fill();
    return (mq.size() + BPR - 1) / BPR;
  endfunction

  task automatic check_outputs();
    chk("m_valid", {31'd0, sif.m_valid}, {31'd0, mq.size() != 0});
    chk("m_data", sif.m_data, (mq.size() != 0) ? mq[0].d : 32'd0);
    chk("m_last", {31'd0, sif.m_last}, (mq.size() != 0) ? {31'd0, mq[0].l} : 32'd0);
    chk("fill_level", {27'd0, fill_level}, model_fill());
    chk("drop_count", {16'd0, drop_count}, m_drop);
    chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
    chk("spike_count", {16'd0, spike_count}, m_spk);
  endtask

  // One clock cycle: drive inputs, compare current outputs, then advance the model.
  task automatic cycle(input bit r, input bit ev_v, input logic [31:0] ev, input bit sp, input bit rdy);
    bit    full;
    beat_t b;
    rst         = r;
    event_valid = ev_v;
    event_in    = ev;
    spike_in    = sp;
    sif.m_ready = rdy;
    if (do_chk) check_outputs();
    @(posedge clk);
    if (r) begin
      mq.delete();
      m_ts   = 32'd0;
      m_drop = 0;
      m_spk  = 0;
      m_ovf  = 1'b0;
    end else begin
      full = (model_fill() >= DEPTH);
      if (mq.size() != 0 && rdy) void'(mq.pop_front());
      if (ev_v && !full) begin
        if (BPR == 2) begin
          b.d = m_ts; b.l = 1'b0; mq.push_back(b);
        end
        b.d = ev; b.l = 1'b1; mq.push_back(b);
      end
      if (ev_v && full) begin
        m_ovf = 1'b1;
        if (m_drop < 65535) m_drop++;
      end
      if (sp && m_spk < 65535) m_spk++;
      m_ts = m_ts + 32'd1;
    end
    #1;
  endtask

  // Directed vectors: inputs for one cycle, outputs expected just after that edge.
  typedef struct {
    logic        r;
    logic        ev_v;
    logic [31:0] ev;
    logic        sp;
    logic        rdy;
    logic        exp_v;
    logic [31:0] exp_d;
    logic        exp_l;
    int          exp_fill;
    int          exp_spk;
  } vec_t;

  vec_t vecs[14];

  initial begin
    int k;

    rst = 1'b1; event_valid = 1'b0; event_in = '0; spike_in = 1'b0; sif.m_ready = 1'b0;
    do_chk = 1'b0;

    vecs[0] = '{1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 0, 0};
    vecs[1] = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 0, 0};
    vecs[2] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 0, 1};
    vecs[3] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 0, 2};
    vecs[4] = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 0, 2};
    vecs[5] = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 0, 2};
`ifdef EVENT_TIMESTAMP_EN
    vecs[6]  = '{1'b0, 1'b1, 32'hA1, 1'b0, 1'b1, 1'b1, 32'h5,  1'b0, 1, 2};
    vecs[7]  = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 32'hA1, 1'b1, 1, 2};
    vecs[8]  = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 0, 2};
    vecs[9]  = '{1'b0, 1'b1, 32'hB2, 1'b0, 1'b0, 1'b1, 32'h8,  1'b0, 1, 2};
    vecs[10] = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 32'h8,  1'b0, 1, 2};
    vecs[11] = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 32'hB2, 1'b1, 1, 2};
    vecs[12] = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 32'hB2, 1'b1, 1, 2};
    vecs[13] = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 0, 2};
`else
    vecs[6]  = '{1'b0, 1'b1, 32'hA1, 1'b0, 1'b1, 1'b1, 32'hA1, 1'b1, 1, 2};
    vecs[7]  = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 0, 2};
    vecs[8]  = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 0, 2};
    vecs[9]  = '{1'b0, 1'b1, 32'hB2, 1'b0, 1'b0, 1'b1, 32'hB2, 1'b1, 1, 2};
    vecs[10] = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 32'hB2, 1'b1, 1, 2};
    vecs[11] = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 0, 2};
    vecs[12] = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 0, 2};
    vecs[13] = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 0, 2};
`endif

    for (int i = 0; i < 14; i++) begin
      rst         = vecs[i].r;
      event_valid = vecs[i].ev_v;
      event_in    = vecs[i].ev;
      spike_in    = vecs[i].sp;
      sif.m_ready = vecs[i].rdy;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_valid", i), {31'd0, sif.m_valid}, {31'd0, vecs[i].exp_v});
      chk($sformatf("vec%0d_data", i), sif.m_data, vecs[i].exp_d);
      chk($sformatf("vec%0d_last", i), {31'd0, sif.m_last}, {31'd0, vecs[i].exp_l});
      chk($sformatf("vec%0d_fill", i), {27'd0, fill_level}, vecs[i].exp_fill);
      chk($sformatf("vec%0d_spike", i), {16'd0, spike_count}, vecs[i].exp_spk);
    end

    // Resynchronise the model with a reset; checking resumes from the next cycle.
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    do_chk = 1'b1;

    // Overflow: 17 writes with the consumer stalled.
    for (int i = 0; i < 17; i++) cycle(1'b0, 1'b1, 32'h100 + i, 1'b0, 1'b0);
    chk("ovf_fill", {27'd0, fill_level}, DEPTH);
    chk("ovf_drop", {16'd0, drop_count}, 32'd1);
    chk("ovf_flag", {31'd0, overflow}, 32'd1);

    // Writes while full are dropped even on the cycle the head entry pops.
    for (int i = 0; i < BPR; i++) cycle(1'b0, 1'b1, 32'hDEAD, 1'b0, 1'b1);
    chk("popfull_drop", {16'd0, drop_count}, 1 + BPR);
    chk("popfull_fill", {27'd0, fill_level}, DEPTH - 1);

    // Drain: the remaining retained events must arrive in write order.
    k = 0;
    for (int c = 0; c < DEPTH * BPR + 8; c++) begin
      if (sif.m_valid && sif.m_last) begin
        chk("drain_order", sif.m_data, 32'h101 + k);
        k++;
      end
      cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    end
    chk("drain_count", k, DEPTH - 1);

    // Reset in the middle of a record (after the head beat) discards everything.
    cycle(1'b0, 1'b1, 32'hC3, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 32'hEE, 1'b1, 1'b1);
    chk("midrst_valid", {31'd0, sif.m_valid}, 32'd0);
    chk("midrst_last", {31'd0, sif.m_last}, 32'd0);
    chk("midrst_fill", {27'd0, fill_level}, 32'd0);
    chk("midrst_drop", {16'd0, drop_count}, 32'd0);
    chk("midrst_ovf", {31'd0, overflow}, 32'd0);
    chk("midrst_spike", {16'd0, spike_count}, 32'd0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    chk("midrst_no_tail", {31'd0, sif.m_valid}, 32'd0);

    // Random traffic with varying consumer throughput and occasional resets.
    for (int seg = 0; seg < 3; seg++) begin
      for (int c = 0; c < 1000; c++) begin
        cycle($urandom_range(0, 399) == 0, $urandom_range(0, 1) == 1, $urandom,
              $urandom_range(0, 1) == 1, $urandom_range(0, 9) < (seg * 4 + 2));
      end
    end

    // Spike counter saturation; per-cycle checks are paused to keep the log short.
    do_chk = 1'b0;
    for (int c = 0; c < 70000; c++) cycle(1'b0, 1'b0, 32'h0, 1'b1, $urandom_range(0, 1) == 1);
    chk("spike_sat", {16'd0, spike_count}, 32'h0000FFFF);
    do_chk = 1'b1;

    // Events after the long run carry the advanced timestamp.
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 32'h300 + i, 1'b0, 1'b0);
    for (int c = 0; c < 3 * BPR + 4; c++) cycle(1'b0, 1'b0, 32'h0, 1'b0, $urandom_range(0, 1) == 1);
    for (int c = 0; c < 3 * BPR + 4; c++) cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    chk("final_empty", {27'd0, fill_level}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/event_stream_buffer.md
EVENT_STREAM_BUFFER -- requirements
Module: event_stream_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, meaning FIFO entries; legal values are powers of two, 2 to 256.
REQ-002 The block SHALL have port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, meaning reset; synchronous and active-high.
REQ-004 The block SHALL have port event_in, input, 32, meaning the classified event word from the classifier stage.
REQ-005 The block SHALL have port event_valid, input, 1, meaning event_in is a new event this cycle (one-cycle pulse per event).
REQ-006 The block SHALL have port spike_in, input, 1, meaning the raw spike-detection flag from the detector.
REQ-007 The block SHALL have port m_data, output, 32, meaning the stream data beat.
REQ-008 The block SHALL have port m_valid, output, 1, meaning m_data holds a valid beat.
REQ-009 The block SHALL have port m_ready, input, 1, meaning the consumer accepts the beat.
REQ-010 The block SHALL have port m_last, output, 1, meaning the current beat is the final beat of an event record.
REQ-011 The block SHALL have port fill_level, output, log2(DEPTH)+1, meaning the number of occupied entries.
REQ-012 The block SHALL have port drop_count, output, 16, meaning the count of events dropped because the FIFO was full.
REQ-013 The block SHALL have port overflow, output, 1, meaning at least one event has been dropped since reset (sticky).
REQ-014 The block SHALL have port spike_count, output, 16, meaning the number of cycles with spike_in=1 since reset.

Function
REQ-015 A free-running 32-bit timestamp counter SHALL increment every cycle and wrap from 0xFFFFFFFF to 0.
REQ-016 On a cycle with event_valid=1 and the FIFO not full, the block SHALL write {timestamp value that cycle, event_in} as one entry.
REQ-017 Full status SHALL be evaluated at the start of the cycle; a write while full SHALL be dropped even if a pop occurs in the same cycle.
REQ-018 Each dropped event SHALL increment drop_count, saturating at 0xFFFF, and SHALL set overflow.
REQ-019 A simultaneous accepted write and pop SHALL leave fill_level unchanged.
REQ-020 The path SHALL have no bypass: an event written into an empty FIFO SHALL first appear with m_valid=1 on the next cycle.
REQ-021 m_valid SHALL equal (fill_level != 0).
REQ-022 A beat SHALL transfer on a cycle with m_valid=1 and m_ready=1.
REQ-023 m_data and m_last SHALL remain stable while m_valid=1 and m_ready=0.
REQ-024 The beat state machine SHALL have two states, BEAT_HEAD and BEAT_TAIL.
REQ-025 In BEAT_HEAD, m_data SHALL be the entry's timestamp and m_last SHALL be 0; on transfer the machine SHALL go to BEAT_TAIL.
REQ-026 In BEAT_TAIL, m_data SHALL be the entry's event word and m_last SHALL be 1; on transfer the block SHALL pop the entry and return to BEAT_HEAD.
REQ-027 The state machine SHALL not leave BEAT_HEAD while the FIFO is empty.
REQ-028 spike_count SHALL increment on each cycle with spike_in=1, saturating at 0xFFFF.
REQ-029 Read and write pointers SHALL wrap modulo DEPTH.

Reset
REQ-030 With rst=1 at a clock edge, the block SHALL set fill_level=0, m_valid=0, m_last=0, m_data=0, drop_count=0, overflow=0, spike_count=0, timestamp=0, pointers=0 and state=BEAT_HEAD.
REQ-031 Reset asserted mid-record SHALL discard all stored entries, including a partially sent record; no tail beat SHALL follow after reset.
REQ-032 event_valid and spike_in SHALL be ignored on cycles with rst=1.

Configuration
REQ-033 Macro EVENT_TIMESTAMP_EN, when defined, SHALL enable the timestamp counter and two-beat records (REQ-015, REQ-024 to REQ-026).
REQ-034 When EVENT_TIMESTAMP_EN is not defined, the block SHALL omit the timestamp storage and counter, and each record SHALL be one beat with m_data=event word and m_last=1; all other requirements are unchanged.

Verification
REQ-035 Scenario: reset, event_valid pulse at timestamp 5 with event_in=0x0000_00A1, m_ready=1 -> beat 0x00000005/last=0 then beat 0x000000A1/last=1; fill_level returns to 0.
REQ-036 Scenario: m_ready=0, write 17 events with DEPTH=16 -> fill_level=16, drop_count=1, overflow=1; after draining, the 16 retained events arrive in order.
REQ-037 Scenario: m_ready toggling 1/0 every cycle during a record -> m_data is held during stalls; no beat is lost or duplicated.
REQ-038 Scenario: rst asserted after the head beat transfers, before the tail -> m_valid=0 the next cycle and all counters are 0.
REQ-039 Scenario: spike_in=1 for 70000 cycles -> spike_count=0xFFFF; timestamp wrap past 0xFFFFFFFF gives the next event timestamp 0x00000000+n.
REQ-040 Scenario: build without EVENT_TIMESTAMP_EN, with 3 events -> 3 single beats, each with m_last=1.
